// File: rtl/inst_fetch_bridge.sv
// Instruction-cache miss service engine: latches the missing PC, performs one
// word read on the SRAM-like instruction bus, and hands the word back for one cycle.
module inst_fetch_bridge #(
    parameter bit          PHYS_MAP      = 1'b1,
    parameter logic [31:0] MISALIGN_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interface_enable,
    input  logic [31:0] interface_PC,
    output logic [31:0] this_time_pc,
    output logic [31:0] interface_instruction,
    output logic        cache_wait_stop_choke,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_lat_q, pc_lat_d;
    logic [31:0] data_lat_q, data_lat_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_lat_q   <= 32'h0000_0000;
            data_lat_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_lat_q   <= pc_lat_d;
            data_lat_q <= data_lat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_lat_d   = pc_lat_q;
        data_lat_d = data_lat_q;
        unique case (state_q)
            IDLE: begin
                if (interface_enable) begin
                    pc_lat_d = interface_PC;
                    if (interface_PC[1:0] == 2'b00) begin
                        state_d = REQ;
                    end else begin
                        // Misaligned fetches never touch the bus.
                        data_lat_d = MISALIGN_WORD;
                        state_d    = DONE;
                    end
                end
            end
            REQ: begin
                if (inst_addr_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (inst_data_ok) begin
                    // A redirected or dropped miss makes this response stale.
                    if (interface_enable && (interface_PC == pc_lat_q)) begin
                        data_lat_d = inst_rdata;
                        state_d    = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inst_req              = (state_q == REQ);
    assign cache_wait_stop_choke = (state_q != DONE);
    assign this_time_pc          = pc_lat_q;
    assign interface_instruction = data_lat_q;

    // kseg0/kseg1 alias onto the low 512 MiB of physical space.
    assign inst_addr = (PHYS_MAP && (pc_lat_q[31:30] == 2'b10))
                     ? {3'b000, pc_lat_q[28:0]}
                     : pc_lat_q;

endmodule
